// File: rtl/pong_pkg.sv
// Shared constants and types for the pong ball/paddle blocks.
package pong_pkg;

   localparam int unsigned D_WIDTH  = 640;
   localparam int unsigned D_HEIGHT = 480;
   localparam int unsigned PADDLE_W = 100;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_STILL = 2'd2;

   typedef enum logic [1:0] {
      ST_STILL = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } paddle_state_e;

   // Map the direction FSM state onto the code the ball consumes.
   function automatic logic [1:0] dir_code(input paddle_state_e s);
      case (s)
         ST_LEFT:  dir_code = DIR_LEFT;
         ST_RIGHT: dir_code = DIR_RIGHT;
         default:  dir_code = DIR_STILL;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_btn
);

   localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          sync1_q;
   logic          sync2_q;
   logic          db_q;
   logic          db_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any return to the accepted level restarts the stability window.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CW'(DB_CYCLES - 1)) begin
            db_d  = ~db_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign o_btn = db_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position register, edge clamping and travel-direction FSM driven by
// two debounced push-buttons; advances once per animation strobe.
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned IX        = 270,
   parameter int unsigned P_WIDTH   = PADDLE_W,
   parameter int unsigned X_MIN     = 0,
   parameter int unsigned X_MAX     = D_WIDTH - PADDLE_W,
   parameter int unsigned STEP      = 4,
   parameter int unsigned DB_CYCLES = 250000,
   parameter int unsigned DIR_HOLD  = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ani_stb,
   input  logic        i_animate,
   input  logic        i_btn_left,
   input  logic        i_btn_right,
   output logic [11:0] o_x,
   output logic [11:0] o_x2,
   output logic [1:0]  o_dir
);

   localparam int unsigned HW = (DIR_HOLD > 0) ? $clog2(DIR_HOLD + 1) : 1;

   logic               btn_l;
   logic               btn_r;
   logic [11:0]        x_q;
   logic [11:0]        x_d;
   logic [11:0]        nx;
   logic signed [12:0] xs;
   logic signed [12:0] x_dec;
   logic signed [12:0] x_inc;
   logic [HW-1:0]      hold_q;
   logic [HW-1:0]      hold_d;
   logic [1:0]         dir_q;
   logic [1:0]         dir_d;
   paddle_state_e      state_q;
   paddle_state_e      state_d;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_btn (i_btn_left),
      .o_btn (btn_l)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_btn (i_btn_right),
      .o_btn (btn_r)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x_q     <= 12'(IX);
         hold_q  <= '0;
         state_q <= ST_STILL;
         dir_q   <= DIR_STILL;
      end else begin
         x_q     <= x_d;
         hold_q  <= hold_d;
         state_q <= state_d;
         dir_q   <= dir_d;
      end
   end

   // Signed 13-bit arithmetic keeps x - STEP from wrapping below zero.
   always_comb begin
      x_d     = x_q;
      hold_d  = hold_q;
      state_d = state_q;
      xs      = $signed({1'b0, x_q});
      x_dec   = xs - $signed(13'(STEP));
      x_inc   = xs + $signed(13'(STEP));
      nx      = x_q;

      if (btn_l && !btn_r) begin
         nx = (x_dec < $signed(13'(X_MIN))) ? 12'(X_MIN) : 12'(x_dec);
      end else if (btn_r && !btn_l) begin
         nx = (x_inc > $signed(13'(X_MAX))) ? 12'(X_MAX) : 12'(x_inc);
      end

      // Clamped strobes count as no motion so the hold decays at the walls.
      if (i_animate && i_ani_stb) begin
         x_d = nx;
         if (nx != x_q) begin
            state_d = (nx < x_q) ? ST_LEFT : ST_RIGHT;
            hold_d  = HW'(DIR_HOLD);
         end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
               state_d = ST_STILL;
            end
         end
      end

      dir_d = dir_code(state_d);
   end

   assign o_x   = x_q;
   assign o_x2  = x_q + 12'(P_WIDTH);
   assign o_dir = dir_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: strobe-level vector table plus hand-written
// sequences for async reset, debounce latency/glitch and left-wall clamping.
module tb_paddle_ctrl;

   logic        clk;
   logic        rst;
   logic        ani_stb;
   logic        animate;
   logic        btn_left;
   logic        btn_right;
   logic [11:0] x;
   logic [11:0] x2;
   logic [1:0]  dir;

   int n_tests;
   int n_fail;

   typedef struct {
      logic l;
      logic r;
      logic anim;
      int   n_stb;
      int   exp_x;
      int   exp_dir;
   } vec_t;

   vec_t vecs [19];

   paddle_ctrl #(
      .DB_CYCLES (4),
      .STEP      (4),
      .DIR_HOLD  (3)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_ani_stb   (ani_stb),
      .i_animate   (animate),
      .i_btn_left  (btn_left),
      .i_btn_right (btn_right),
      .o_x         (x),
      .o_x2        (x2),
      .o_dir       (dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input int ex, input int ed);
      check({name, " x"},   int'(x),   ex);
      check({name, " x2"},  int'(x2),  ex + 100);
      check({name, " dir"}, int'(dir), ed);
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle strobe, then idle so the frame spacing is 10 clocks.
   task automatic strobe(input int n);
      repeat (n) begin
         @(negedge clk);
         ani_stb = 1'b1;
         @(negedge clk);
         ani_stb = 1'b0;
         clks(8);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      ani_stb   = 1'b0;
      animate   = 1'b1;
      btn_left  = 1'b0;
      btn_right = 1'b0;

      //            l     r     anim  n   x    dir
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 5,  290, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1,  290, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1,  290, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1,  290, 2};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 2,  290, 2};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 5,  290, 2};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1,  294, 0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1,  290, 1};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1,  290, 1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 2,  290, 2};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 10, 330, 0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1,  326, 1};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 3,  326, 1};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 2,  326, 1};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1,  326, 2};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 53, 538, 0};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 1,  540, 0};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 1,  540, 0};
      vecs[18] = '{1'b0, 1'b1, 1'b1, 2,  540, 2};

      clks(3);
      rst = 1'b0;
      clks(2);
      check_out("reset", 270, 2);

      foreach (vecs[i]) begin
         animate   = vecs[i].anim;
         btn_left  = vecs[i].l;
         btn_right = vecs[i].r;
         clks(8);
         strobe(vecs[i].n_stb);
         check_out($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_dir);
      end

      // Move left off the wall, then reset asynchronously between edges.
      animate   = 1'b1;
      btn_left  = 1'b1;
      btn_right = 1'b0;
      clks(8);
      strobe(2);
      check_out("pre_rst", 532, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_out("async_rst", 270, 2);
      btn_left = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      clks(8);
      check_out("post_rst", 270, 2);

      // A 3-clock right glitch must never be accepted.
      btn_right = 1'b1;
      clks(3);
      btn_right = 1'b0;
      clks(3);
      strobe(1);
      check_out("glitch", 270, 2);

      // Accepted exactly 2 + DB_CYCLES clocks after the press.
      @(negedge clk);
      btn_right = 1'b1;
      clks(5);
      ani_stb = 1'b1;
      @(negedge clk);
      ani_stb = 1'b0;
      check_out("db_early", 270, 2);
      ani_stb = 1'b1;
      @(negedge clk);
      ani_stb = 1'b0;
      check_out("db_accept", 274, 0);

      // Left wall: 274 -> 6 -> 2 -> 0, then the hold decays while clamped.
      btn_right = 1'b0;
      btn_left  = 1'b1;
      clks(8);
      strobe(67);
      check_out("left6", 6, 1);
      strobe(1);
      check_out("left2", 2, 1);
      strobe(1);
      check_out("left0", 0, 1);
      strobe(1);
      check_out("clamp1", 0, 1);
      strobe(1);
      check_out("clamp2", 0, 1);
      strobe(1);
      check_out("clamp3", 0, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
